// File: rtl/reg_bist_pkg.sv
// Shared types and constants for the register BIST master: FSM states,
// the four test patterns, the address stride and the fail-counter width.
package reg_bist_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;

  localparam logic [31:0] PAT_ONES  = 32'hffff_ffff;
  localparam logic [31:0] PAT_ZEROS = 32'h0000_0000;
  localparam logic [31:0] PAT_AA    = 32'haaaa_aaaa;
  localparam logic [31:0] PAT_55    = 32'h5555_5555;

  localparam int NUM_PATS    = 4;
  localparam int PAT_IDX_W   = 2;
  localparam int ADDR_STRIDE = 4;
  localparam int FAIL_CNT_W  = 8;

  function automatic logic [31:0] pat_word(input logic [PAT_IDX_W-1:0] idx);
    case (idx)
      2'd0:    pat_word = PAT_ONES;
      2'd1:    pat_word = PAT_ZEROS;
      2'd2:    pat_word = PAT_AA;
      default: pat_word = PAT_55;
    endcase
  endfunction

endpackage

// File: rtl/reg_bist_if.sv
// Simple register bus between the BIST master and the register block under test.
interface reg_bist_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/reg_bist_patgen.sv
// Maps a pattern index to its 32-bit test word replicated across DW bits.
module reg_bist_patgen
  import reg_bist_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [PAT_IDX_W-1:0] pat_idx,
  output logic [DW-1:0]        pattern
);

  logic [31:0] pat32;

  always_comb begin
    pat32   = pat_word(pat_idx);
    pattern = '0;
    for (int i = 0; i < DW; i++) begin
      pattern[i] = pat32[5'(i % 32)];
    end
  end

endmodule

// File: rtl/reg_bist_master.sv
// Register BIST master: writes each pattern to each register, reads it back
// after a one-cycle gap and logs masked miscompares.
//   state | meaning
//   IDLE  | waiting for start, bus quiet
//   WRITE | wr_en strobe with current pattern
//   GAP   | one idle bus cycle between write and read
//   READ  | rd_en strobe, compare at closing edge
//   DONE  | run finished, results held
module reg_bist_master
  import reg_bist_pkg::*;
#(
  parameter int            DW        = 32,
  parameter int            AW        = 10,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            NUM_REGS  = 4,
  parameter logic [DW-1:0] MASK      = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  reg_bist_if.master            bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FAIL_CNT_W-1:0] fail_cnt,
  output logic [AW-1:0]         first_fail_addr,
  output logic [DW-1:0]         first_fail_data
);

  localparam int RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t                 state_q, state_nxt;
  logic [RI_W-1:0]        reg_idx_q, reg_idx_nxt;
  logic [PAT_IDX_W-1:0]   pat_idx_q, pat_idx_nxt;
  logic [DW-1:0]          pat_nxt;
  logic [DW-1:0]          exp_q;
  logic [AW-1:0]          addr_nxt;
  logic                   last_step;
  logic                   miscmp;

  reg_bist_patgen #(.DW(DW)) u_patgen (
    .pat_idx (pat_idx_nxt),
    .pattern (pat_nxt)
  );

  assign last_step = (pat_idx_q == PAT_IDX_W'(NUM_PATS - 1)) &&
                     (reg_idx_q == RI_W'(NUM_REGS - 1));
  assign miscmp    = (state_q == READ) && ((bus.rdata & MASK) != (exp_q & MASK));
  assign addr_nxt  = BASE_ADDR + AW'(ADDR_STRIDE * int'(reg_idx_nxt));
  assign pass      = done && (fail_cnt == '0);

  always_comb begin
    state_nxt   = state_q;
    reg_idx_nxt = reg_idx_q;
    pat_idx_nxt = pat_idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt   = WRITE;
          reg_idx_nxt = '0;
          pat_idx_nxt = '0;
        end
      end
      WRITE: state_nxt = GAP;
      GAP:   state_nxt = READ;
      READ: begin
        if (last_step) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WRITE;
          if (pat_idx_q == PAT_IDX_W'(NUM_PATS - 1)) begin
            pat_idx_nxt = '0;
            reg_idx_nxt = reg_idx_q + 1'b1;
          end else begin
            pat_idx_nxt = pat_idx_q + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      reg_idx_q       <= '0;
      pat_idx_q       <= '0;
      exp_q           <= '0;
      bus.wr_en       <= 1'b0;
      bus.rd_en       <= 1'b0;
      bus.addr        <= '0;
      bus.wdata       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else begin
      state_q   <= state_nxt;
      reg_idx_q <= reg_idx_nxt;
      pat_idx_q <= pat_idx_nxt;
      bus.wr_en <= (state_nxt == WRITE);
      bus.rd_en <= (state_nxt == READ);
      bus.addr  <= (state_nxt == WRITE || state_nxt == READ) ? addr_nxt : '0;
      bus.wdata <= (state_nxt == WRITE) ? pat_nxt : '0;
      if (state_nxt == WRITE) exp_q <= pat_nxt;

      if (state_q == IDLE && start) begin
        busy            <= 1'b1;
        done            <= 1'b0;
        fail_cnt        <= '0;
        first_fail_addr <= '0;
        first_fail_data <= '0;
      end

      if (miscmp) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (fail_cnt == '0) begin
          first_fail_addr <= bus.addr;
          first_fail_data <= bus.rdata & MASK;
        end
      end

      if (state_nxt == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bist_master.sv
// Bench for reg_bist_master: RW slave models with injectable stuck bits,
// directed and random fault runs checked against a pattern-level model.
module tb_reg_bist_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;

  logic        busy_a, done_a, pass_a;
  logic [7:0]  fcnt_a;
  logic [9:0]  ffa_a;
  logic [31:0] ffd_a;

  logic        busy_m, done_m, pass_m;
  logic [7:0]  fcnt_m;
  logic [9:0]  ffa_m;
  logic [31:0] ffd_m;

  // Fault controls for slave A
  bit          zero_all;
  logic [9:0]  f_addr;
  logic [31:0] sa_mask, sa_val;

  logic [31:0] mem_a [4];
  logic [31:0] mem_m [4];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  reg_bist_if #(.DW(32), .AW(10)) bus_a ();
  reg_bist_if #(.DW(32), .AW(10)) bus_m ();

  reg_bist_master #(.DW(32), .AW(10), .BASE_ADDR(10'h0), .NUM_REGS(4),
                    .MASK(32'hffff_ffff)) dut (
    .clk (clk), .rst (rst), .start (start), .bus (bus_a),
    .busy (busy_a), .done (done_a), .pass (pass_a), .fail_cnt (fcnt_a),
    .first_fail_addr (ffa_a), .first_fail_data (ffd_a)
  );

  reg_bist_master #(.DW(32), .AW(10), .BASE_ADDR(10'h0), .NUM_REGS(4),
                    .MASK(32'hffff_fffe)) dut_m (
    .clk (clk), .rst (rst), .start (start), .bus (bus_m),
    .busy (busy_m), .done (done_m), .pass (pass_m), .fail_cnt (fcnt_m),
    .first_fail_addr (ffa_m), .first_fail_data (ffd_m)
  );

  always @(posedge clk) if (bus_a.wr_en) mem_a[bus_a.addr[3:2]] <= bus_a.wdata;
  always @(posedge clk) if (bus_m.wr_en) mem_m[bus_m.addr[3:2]] <= bus_m.wdata;

  assign bus_a.rdata = zero_all ? 32'h0 :
                       (bus_a.addr == f_addr) ? ((mem_a[bus_a.addr[3:2]] & ~sa_mask) | (sa_val & sa_mask))
                                              : mem_a[bus_a.addr[3:2]];
  // Slave M always has bit 0 of register 0x8 stuck at 0.
  assign bus_m.rdata = (bus_m.addr == 10'h8) ? (mem_m[bus_m.addr[3:2]] & 32'hffff_fffe)
                                             : mem_m[bus_m.addr[3:2]];

  function automatic logic [31:0] pat_of(input int k);
    case (k)
      0:       return 32'hffff_ffff;
      1:       return 32'h0000_0000;
      2:       return 32'haaaa_aaaa;
      default: return 32'h5555_5555;
    endcase
  endfunction

  // Write every pattern to every register, read back through the fault, compare masked.
  function automatic void model(input logic [31:0] mask, input bit zall, input logic [9:0] fa,
                                input logic [31:0] smask, input logic [31:0] sval,
                                output int fc, output logic [9:0] effa, output logic [31:0] effd);
    logic [31:0] w, obs;
    logic [9:0]  a;
    fc = 0; effa = '0; effd = '0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        a = 10'(4 * r);
        w = pat_of(p);
        if (zall)         obs = 32'h0;
        else if (a == fa) obs = (w & ~smask) | (sval & smask);
        else              obs = w;
        if ((obs & mask) != (w & mask)) begin
          if (fc == 0) begin effa = a; effd = obs & mask; end
          if (fc < 255) fc++;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_check(input string tag, input int restart_at, input int reset_at);
    int          cyc, n_wr, n_rd, efc;
    logic [9:0]  effa;
    logic [31:0] effd;
    model(32'hffff_ffff, zero_all, f_addr, sa_mask, sa_val, efc, effa, effd);
    cyc = 0; n_wr = 0; n_rd = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (busy_a && cyc < 200) begin
      cyc++;
      chk({tag, ":excl"}, 64'(bus_a.wr_en & bus_a.rd_en), 64'd0);
      if (bus_a.wr_en) begin
        chk({tag, ":waddr"}, 64'(bus_a.addr), 64'(4 * (n_wr / 4)));
        chk({tag, ":wdata"}, 64'(bus_a.wdata), 64'(pat_of(n_wr % 4)));
        n_wr++;
      end else if (bus_a.rd_en) begin
        chk({tag, ":raddr"}, 64'(bus_a.addr), 64'(4 * (n_rd / 4)));
        n_rd++;
      end else begin
        chk({tag, ":gap_bus"}, {bus_a.wdata, 22'd0, bus_a.addr}, 64'd0);
      end
      start = (cyc == restart_at);
      if (cyc == reset_at) begin
        rst = 1'b1;
        #1;
        chk({tag, ":rst_wr_rd"}, 64'({bus_a.wr_en, bus_a.rd_en}), 64'd0);
        chk({tag, ":rst_busy"}, 64'(busy_a), 64'd0);
        chk({tag, ":rst_done"}, 64'(done_a), 64'd0);
        chk({tag, ":rst_fcnt"}, 64'(fcnt_a), 64'd0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);
        chk({tag, ":post_rst_done"}, 64'(done_a), 64'd0);
        chk({tag, ":post_rst_busy"}, 64'(busy_a), 64'd0);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ":busy_cycles"}, 64'(cyc), 64'd48);
    chk({tag, ":n_writes"}, 64'(n_wr), 64'd16);
    chk({tag, ":n_reads"}, 64'(n_rd), 64'd16);
    chk({tag, ":done"}, 64'(done_a), 64'd1);
    chk({tag, ":pass"}, 64'(pass_a), 64'(efc == 0));
    chk({tag, ":fail_cnt"}, 64'(fcnt_a), 64'(efc));
    chk({tag, ":ff_addr"}, 64'(ffa_a), 64'(effa));
    chk({tag, ":ff_data"}, 64'(ffd_a), 64'(effd));
    chk({tag, ":m_done"}, 64'(done_m), 64'd1);
    chk({tag, ":m_pass"}, 64'(pass_m), 64'd1);
    chk({tag, ":m_fail_cnt"}, 64'(fcnt_m), 64'd0);
    @(negedge clk);
    chk({tag, ":idle_done_hold"}, 64'({done_a, busy_a}), 64'b10);
    chk({tag, ":idle_bus"}, {bus_a.wdata, 20'd0, bus_a.wr_en, bus_a.rd_en, bus_a.addr}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    zero_all = 1'b0; f_addr = 10'h3ff; sa_mask = '0; sa_val = '0;
    repeat (2) @(negedge clk);
    chk("reset:flags", 64'({busy_a, done_a, pass_a}), 64'd0);
    chk("reset:fail", {ffd_a, 14'd0, fcnt_a, ffa_a}, 64'd0);
    chk("reset:bus", {bus_a.wdata, 20'd0, bus_a.wr_en, bus_a.rd_en, bus_a.addr}, 64'd0);
    chk("reset:m_flags", 64'({busy_m, done_m, pass_m, fcnt_m}), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_check("ideal", -1, -1);

    f_addr = 10'h8; sa_mask = 32'h1; sa_val = 32'h0;
    run_check("stuck", -1, -1);
    chk("stuck:lit_fcnt", 64'(fcnt_a), 64'd2);
    chk("stuck:lit_ffa", 64'(ffa_a), 64'h8);
    chk("stuck:lit_ffd", 64'(ffd_a), 64'hffff_fffe);

    run_check("restart10", 10, -1);

    zero_all = 1'b1;
    run_check("zeros", -1, -1);
    chk("zeros:lit_fcnt", 64'(fcnt_a), 64'd12);
    zero_all = 1'b0;

    f_addr = 10'h3ff; sa_mask = '0;
    run_check("rst20", -1, 20);
    run_check("after_rst", -1, -1);

    for (int k = 0; k < 6; k++) begin
      f_addr  = 10'(4 * $urandom_range(0, 3));
      sa_mask = $urandom;
      sa_val  = $urandom;
      run_check($sformatf("rand%0d", k), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
